// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the ALU command sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND     = 4'd0;
  localparam logic [3:0] OP_NOR     = 4'd1;
  localparam logic [3:0] OP_NAND    = 4'd2;
  localparam logic [3:0] OP_OR      = 4'd3;
  localparam logic [3:0] OP_XOR     = 4'd4;
  localparam logic [3:0] OP_NOT     = 4'd5;
  localparam logic [3:0] OP_ADD     = 4'd6;
  localparam logic [3:0] OP_SUB     = 4'd7;
  localparam logic [3:0] OP_CMP     = 4'd8;
  localparam logic [3:0] OP_MUL     = 4'd9;
  localparam logic [3:0] OP_EVENPAR = 4'd10;
  localparam logic [3:0] OP_ODDPAR  = 4'd11;
  localparam logic [3:0] OP_DEC     = 4'd12;
  localparam logic [3:0] OP_INC     = 4'd13;
  localparam logic [3:0] OP_XNOR    = 4'd14;
  localparam logic [3:0] OP_SHIFT   = 4'd15;

  // Bit positions inside the 7-bit flag bus {Cout, Bout, compG, compE, compL, parA, parB}
  localparam int unsigned FLG_COUT  = 6;
  localparam int unsigned FLG_BOUT  = 5;
  localparam int unsigned FLG_COMPG = 4;
  localparam int unsigned FLG_COMPE = 3;
  localparam int unsigned FLG_COMPL = 2;
  localparam int unsigned FLG_PARA  = 1;
  localparam int unsigned FLG_PARB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } seqState_t;

  // Enable vector the ALU decoder must produce for a given select value
  function automatic logic [15:0] selOneHot(input logic [3:0] sel);
    return 16'h0001 << sel;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command/response handshake bundle between a requester and the sequencer.
interface alu_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_shift;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_op;
  logic [7:0] rsp_data;
  logic [6:0] rsp_flags;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_shift, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_op, rsp_data, rsp_flags, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_shift, rsp_ready,
    output cmd_ready, rsp_valid, rsp_op, rsp_data, rsp_flags, rsp_err
  );
endinterface

// File: rtl/alu_sel_onehot_chk.sv
// Flags an ALU enable vector that is not the one-hot decode of the select lines.
module alu_sel_onehot_chk
  import alu_seq_pkg::*;
(
  input  logic [3:0]  sel,
  input  logic [15:0] en,
  output logic        mismatch
);

  // Any extra, missing or misplaced enable bit counts as a mismatch
  always_comb mismatch = (en != selOneHot(sel));

endmodule

// File: rtl/alu_op_sequencer.sv
// Front end for the 16-function 4-bit ALU: accepts a command, holds the ALU
// inputs for SETTLE_CYCLES, captures result/flags and returns a response.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERRW          = 8
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   bus,
  output logic [3:0]          alu_sel,
  output logic [3:0]          alu_a,
  output logic [3:0]          alu_b,
  output logic                alu_shift,
  input  logic [15:0]         alu_en,
  input  logic [7:0]          alu_res,
  input  logic [6:0]          alu_flags,
  output logic [ERRW-1:0]     err_cnt
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  seqState_t  state;
  seqState_t  stateNext;
  logic [3:0] settleCnt;
  logic       accept;
  logic       capture;
  logic       rspDone;
  logic       selMismatch;
  logic [3:0] rspOp;
  logic [7:0] rspData;
  logic [6:0] rspFlags;
  logic       rspErr;

  alu_sel_onehot_chk uChk (
    .sel      (alu_sel),
    .en       (alu_en),
    .mismatch (selMismatch)
  );

  // Handshake events derived from the current state
  always_comb begin
    accept  = (state == ST_IDLE)   && bus.cmd_valid;
    capture = (state == ST_SETTLE) && (settleCnt == '0);
    rspDone = (state == ST_RESP)   && bus.rsp_ready;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    unique case (state)
      ST_IDLE:   if (accept)  stateNext = ST_SETTLE;
      ST_SETTLE: if (capture) stateNext = ST_RESP;
      ST_RESP:   if (rspDone) stateNext = ST_IDLE;
      default:   stateNext = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; cmd_ready only returns a cycle after the response handshake
  always_comb begin
    bus.cmd_ready = (state == ST_IDLE);
    bus.rsp_valid = (state == ST_RESP);
    bus.rsp_op    = rspOp;
    bus.rsp_data  = rspData;
    bus.rsp_flags = rspFlags;
    bus.rsp_err   = rspErr;
  end

  // Settle counter: loaded on acceptance, counts down to the capture cycle
  always_ff @(posedge clk) begin
    if (rst)                                     settleCnt <= '0;
    else if (accept)                             settleCnt <= SETTLE_LOAD;
    else if (state == ST_SETTLE && settleCnt != '0) settleCnt <= settleCnt - 4'd1;
  end

  // ALU drive registers and response opcode, updated only on command acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_sel   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_shift <= 1'b0;
      rspOp     <= '0;
    end else if (accept) begin
      alu_sel   <= bus.cmd_op;
      alu_a     <= bus.cmd_a;
      alu_b     <= bus.cmd_b;
      alu_shift <= bus.cmd_shift;
      rspOp     <= bus.cmd_op;
    end
  end

  // Result capture; held until the next capture
  always_ff @(posedge clk) begin
    if (rst) begin
      rspData  <= '0;
      rspFlags <= '0;
      rspErr   <= 1'b0;
    end else if (capture) begin
      rspData  <= alu_res;
      rspFlags <= alu_flags;
      rspErr   <= selMismatch;
    end
  end

  // Saturating enable-mismatch counter, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)                                          err_cnt <= '0;
    else if (capture && selMismatch && err_cnt != '1) err_cnt <= err_cnt + ERRW'(1);
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Command-side front end for the 16-function 4-bit ALU. It accepts an operation request (opcode plus operands) over a valid/ready handshake and drives the ALU's 4-bit select lines and operands. After a programmable settle time it captures the selected function's result and flags. It also checks the ALU's one-hot enable vector against the issued opcode, and returns the response over a second valid/ready handshake.

Parameters:
SETTLE_CYCLES, 1, cycles the ALU inputs are held before result capture (legal 1..15)
ERRW, 8, width of saturating error counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  request valid
cmd_ready  out  1  request accepted when high with cmd_valid
cmd_op  in  4  opcode 0..15 (0 AND, 1 NOR, 2 NAND, 3 OR, 4 XOR, 5 NOT, 6 ADD, 7 SUB, 8 CMP, 9 MUL, 10 EVENPAR, 11 ODDPAR, 12 DEC, 13 INC, 14 XNOR, 15 SHIFT)
cmd_a  in  4  operand a
cmd_b  in  4  operand b
cmd_shift  in  1  shift control for op 15
alu_sel  out  4  ALU select {A,B,C,D}, bit3 = A
alu_a  out  4  operand a to ALU
alu_b  out  4  operand b to ALU
alu_shift  out  1  shiftCon to ALU
alu_en  in  16  ALU one-hot enable vector E fed back
alu_res  in  8  OR of all E-gated ALU function outputs, zero-extended to 8 bits
alu_flags  in  7  {Cout, Bout, compG, compE, compL, parA, parB}
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when high with rsp_valid
rsp_op  out  4  opcode of this response
rsp_data  out  8  captured result
rsp_flags  out  7  captured flags
rsp_err  out  1  alu_en mismatch at capture
err_cnt  out  ERRW  saturating count of mismatches

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1. FSM goes to IDLE, settle counter to 0.
- FSM states are IDLE, SETTLE, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: register cmd_op to alu_sel and rsp_op, cmd_a to alu_a, cmd_b to alu_b, cmd_shift to alu_shift.
  - Load the counter with SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE:
  - cmd_ready = 0.
  - While the counter is nonzero, decrement it.
  - When the counter is 0, capture: rsp_data = alu_res, rsp_flags = alu_flags, rsp_err = (alu_en != 16'h1 << alu_sel).
  - On capture, increment err_cnt if rsp_err is set; err_cnt saturates at all-ones.
  - Then go to RESP with rsp_valid = 1.
- RESP:
  - cmd_ready = 0. rsp_* are held stable while rsp_valid is high and rsp_ready is low.
  - On rsp_ready: rsp_valid goes to 0 and the FSM returns to IDLE.
  - cmd_ready rises on the following cycle, so a command and a response never complete in the same cycle.
- Latency:
  - Accept at edge N; capture at edge N+SETTLE_CYCLES; rsp_valid is high from cycle N+SETTLE_CYCLES.
  - Throughput is 1 op per SETTLE_CYCLES+2 cycles with rsp_ready held high.
- alu_sel, alu_a, alu_b and alu_shift hold their last values in IDLE and RESP. They change only on command acceptance.
- rsp_data, rsp_flags and rsp_err keep their last capture after the handshake, until the next capture.
- cmd_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.
- Reset mid-operation (any state): the next cycle is IDLE and all outputs are at reset values; an in-flight op is dropped with no response.
- err_cnt is cleared only by rst.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode constants OP_AND..OP_SHIFT (0..15);
  - flag bit indices FLG_COUT=6 .. FLG_PARB=0;
  - the FSM state encoding.
- Sub-module alu_sel_onehot_chk (combinational): takes the 4-bit sel and the 16-bit en, and outputs the mismatch bit.

Test Plan:
- op 0, a=4'hC, b=4'hA, model returns alu_res=8'h08 and alu_en=16'h0001, rsp_ready=1 -> rsp_valid in cycle N+1, rsp_data=8'h08, rsp_err=0, alu_sel=4'h0.
- op 9 (MUL), a=4'hF, b=4'hF, alu_res=8'hE1, SETTLE_CYCLES=3 -> rsp_valid first at cycle N+3, rsp_data=8'hE1, rsp_op=9.
- op 6, rsp_ready held low for 5 cycles -> rsp_* stable, cmd_ready=0 throughout, and a cmd_valid pulse is ignored; after rsp_ready, cmd_ready=1 one cycle later.
- op 3 with alu_en forced to 16'h0000 -> rsp_err=1, err_cnt=1; after 300 such ops err_cnt=8'hFF.
- rst asserted during SETTLE -> next cycle rsp_valid=0, cmd_ready=1, alu_sel=0, err_cnt=0, and no response is issued.
